// File: rtl/tl_d_queue_if.sv
// tl_d_queue_if: bundles the enq/deq handshakes, D-channel beats and occupancy
// of a tl_d_queue so producer and consumer sides can be passed around as one object.
interface tl_d_queue_if #(
  parameter int DATA_W   = 64,
  parameter int SOURCE_W = 6,
  parameter int CNT_W    = 2
);

  typedef struct packed {
    logic [2:0]          opcode;
    logic [1:0]          param;
    logic [2:0]          size;
    logic [SOURCE_W-1:0] source;
    logic                sink;
    logic                denied;
    logic                corrupt;
    logic [DATA_W-1:0]   data;
  } beat_t;

  logic             enq_valid;
  logic             enq_ready;
  beat_t            enq_bits;
  logic             deq_valid;
  logic             deq_ready;
  beat_t            deq_bits;
  logic [CNT_W-1:0] count;

  modport master (
    output enq_valid, enq_bits, deq_ready,
    input  enq_ready, deq_valid, deq_bits, count
  );

  modport slave (
    input  enq_valid, enq_bits, deq_ready,
    output enq_ready, deq_valid, deq_bits, count
  );

endinterface

// File: rtl/tl_d_queue.sv
// tl_d_queue: DEPTH-entry TileLink D-channel FIFO with optional empty bypass (FLOW)
// and enq-while-full pipelining (PIPE). Define TL_D_QUEUE_ASSERT_EN for simulation checks.
module tl_d_queue #(
  parameter int DEPTH    = 2,
  parameter int DATA_W   = 64,
  parameter int SOURCE_W = 6,
  parameter int FLOW     = 0,
  parameter int PIPE     = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      io_enq_valid,
  output logic                      io_enq_ready,
  input  logic [2:0]                io_enq_bits_opcode,
  input  logic [1:0]                io_enq_bits_param,
  input  logic [2:0]                io_enq_bits_size,
  input  logic [SOURCE_W-1:0]       io_enq_bits_source,
  input  logic                      io_enq_bits_sink,
  input  logic                      io_enq_bits_denied,
  input  logic                      io_enq_bits_corrupt,
  input  logic [DATA_W-1:0]         io_enq_bits_data,
  input  logic                      io_deq_ready,
  output logic                      io_deq_valid,
  output logic [2:0]                io_deq_bits_opcode,
  output logic [1:0]                io_deq_bits_param,
  output logic [2:0]                io_deq_bits_size,
  output logic [SOURCE_W-1:0]       io_deq_bits_source,
  output logic                      io_deq_bits_sink,
  output logic                      io_deq_bits_denied,
  output logic                      io_deq_bits_corrupt,
  output logic [DATA_W-1:0]         io_deq_bits_data,
  output logic [$clog2(DEPTH):0]    io_count
);

  localparam int  PTR_W   = $clog2(DEPTH);
  localparam int  CNT_W   = PTR_W + 1;
  localparam int  ENTRY_W = 3 + 2 + 3 + SOURCE_W + 3 + DATA_W;
  localparam bit  FLOW_EN = (FLOW != 0);
  localparam bit  PIPE_EN = (PIPE != 0);

  logic [PTR_W-1:0]   enq_ptr_q, enq_ptr_d;
  logic [PTR_W-1:0]   deq_ptr_q, deq_ptr_d;
  logic               maybe_full_q, maybe_full_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [ENTRY_W-1:0] entry_d;
  logic [ENTRY_W-1:0] head_entry;
  logic [ENTRY_W-1:0] deq_entry;
  logic [PTR_W-1:0]   ptr_diff;
  logic [DEPTH-1:0]   wr_sel;
  logic               ptr_match;
  logic               empty;
  logic               full;
  logic               do_enq;
  logic               do_deq;
  logic               bypass;
  logic               wr_en;
  logic               rd_en;

  assign entry_d = {io_enq_bits_opcode, io_enq_bits_param, io_enq_bits_size,
                    io_enq_bits_source, io_enq_bits_sink, io_enq_bits_denied,
                    io_enq_bits_corrupt, io_enq_bits_data};

  assign ptr_match = (enq_ptr_q == deq_ptr_q);
  assign empty     = ptr_match & ~maybe_full_q;
  assign full      = ptr_match &  maybe_full_q;

  assign io_enq_ready = ~full  | (PIPE_EN & io_deq_ready);
  assign io_deq_valid = ~empty | (FLOW_EN & io_enq_valid);

  assign do_enq = io_enq_valid & io_enq_ready;
  assign do_deq = io_deq_valid & io_deq_ready;

  // A beat that flows through an empty queue is consumed directly and never stored.
  assign bypass = FLOW_EN & empty;
  assign wr_en  = do_enq & ~(bypass & io_deq_ready);
  assign rd_en  = do_deq & ~bypass;

  always_comb begin
    enq_ptr_d    = enq_ptr_q;
    deq_ptr_d    = deq_ptr_q;
    maybe_full_d = maybe_full_q;
    if (wr_en) begin
      enq_ptr_d = enq_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      deq_ptr_d = deq_ptr_q + PTR_W'(1);
    end
    if (wr_en != rd_en) begin
      maybe_full_d = wr_en;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enq_ptr_q    <= '0;
      deq_ptr_q    <= '0;
      maybe_full_q <= 1'b0;
    end else begin
      enq_ptr_q    <= enq_ptr_d;
      deq_ptr_q    <= deq_ptr_d;
      maybe_full_q <= maybe_full_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
    assign wr_sel[gi] = wr_en & (enq_ptr_q == PTR_W'(gi));
  end

  // Payload storage carries no reset; the pointers alone define which slots are live.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_sel[i]) begin
        mem_q[i] <= entry_d;
      end
    end
  end

  assign head_entry = mem_q[deq_ptr_q];
  assign deq_entry  = bypass ? entry_d : head_entry;

  assign {io_deq_bits_opcode, io_deq_bits_param, io_deq_bits_size,
          io_deq_bits_source, io_deq_bits_sink, io_deq_bits_denied,
          io_deq_bits_corrupt, io_deq_bits_data} = deq_entry;

  assign ptr_diff = enq_ptr_q - deq_ptr_q;
  assign io_count = full ? CNT_W'(DEPTH) : {1'b0, ptr_diff};

`ifdef TL_D_QUEUE_ASSERT_EN
`ifndef SYNTHESIS
`ifndef ASSERT_VERBOSE_COND_
  `define ASSERT_VERBOSE_COND_ 1
`endif
`ifndef STOP_COND_
  `define STOP_COND_ 1
`endif

  logic prev_deq_valid_q, prev_deq_valid_d;
  logic prev_do_deq_q, prev_do_deq_d;

  always_comb begin
    prev_deq_valid_d = io_deq_valid;
    prev_do_deq_d    = do_deq;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_deq_valid_q <= 1'b0;
      prev_do_deq_q    <= 1'b0;
    end else begin
      prev_deq_valid_q <= prev_deq_valid_d;
      prev_do_deq_q    <= prev_do_deq_d;
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      if (!FLOW_EN && prev_deq_valid_q && !prev_do_deq_q && !io_deq_valid) begin
        if (`ASSERT_VERBOSE_COND_) $error("tl_d_queue: io_deq_valid dropped without a dequeue");
        if (`STOP_COND_) $fatal(1);
      end
      if (io_count > CNT_W'(DEPTH)) begin
        if (`ASSERT_VERBOSE_COND_) $error("tl_d_queue: io_count exceeds DEPTH");
        if (`STOP_COND_) $fatal(1);
      end
      if ($isunknown(io_enq_valid)) begin
        if (`ASSERT_VERBOSE_COND_) $error("tl_d_queue: io_enq_valid is X");
        if (`STOP_COND_) $fatal(1);
      end
    end
  end
`endif
`endif

endmodule
